// File: rtl/vx_axi_mem_pkg.sv
// vx_axi_mem_pkg: response codes and channel FSM states shared by the AXI memory responder
package vx_axi_mem_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
endpackage

// File: rtl/vx_axi_mem_responder_if.sv
// vx_axi_mem_responder_if: AXI4 AW/W/B/AR/R channels of one AFU memory bank port
interface vx_axi_mem_responder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 25,
  parameter int ID_WIDTH   = 32
);
  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic                    rvalid, rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;
  logic [1:0]              rresp;
  modport master (
    output awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, rready,
    input  awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rlast, rid, rresp
  );
  modport slave (
    input  awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arid, arlen, rready,
    output awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rlast, rid, rresp
  );
endinterface

// File: rtl/vx_axi_mem_ram.sv
// vx_axi_mem_ram: byte-enabled synchronous RAM, one write port and one read-before-write read port
module vx_axi_mem_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int WORDS_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [WORDS_LOG2-1:0]   waddr_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [WORDS_LOG2-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**WORDS_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (we_i && wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  // Only the output register is reset; the array keeps its contents across reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/vx_axi_mem_responder.sv
// vx_axi_mem_responder: AXI4 subordinate memory bank model with independent write and read burst FSMs
module vx_axi_mem_responder
  import vx_axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 25,
  parameter int ID_WIDTH       = 32,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int RD_LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_axi_mem_responder_if.slave s_axi
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int LW  = $clog2(RD_LATENCY + 1);
  typedef logic [MEM_WORDS_LOG2-1:0] idx_t;
  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] a);
    return idx_t'(a >> OFF);
  endfunction
  logic                ready_en_q;
  wr_state_t           wr_q, wr_d;
  idx_t                widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                over_q, over_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  rd_state_t           rd_q, rd_d;
  idx_t                ridx_q, ridx_d, raddr;
  logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic                aw_fire, w_fire, b_fire, ar_fire, r_fire, re;
  assign s_axi.awready = ready_en_q && wr_q == W_IDLE;
  assign s_axi.wready  = wr_q == W_DATA;
  assign s_axi.bvalid  = wr_q == W_RESP;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = ready_en_q && rd_q == R_IDLE;
  assign s_axi.rvalid  = rd_q == R_DATA;
  assign s_axi.rlast   = s_axi.rvalid && rcnt_q == rlen_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = AXI_RESP_OKAY;
  assign aw_fire = s_axi.awvalid && s_axi.awready;
  assign w_fire  = s_axi.wvalid && s_axi.wready;
  assign b_fire  = s_axi.bvalid && s_axi.bready;
  assign ar_fire = s_axi.arvalid && s_axi.arready;
  assign r_fire  = s_axi.rvalid && s_axi.rready;
  always_comb begin
    wr_d    = wr_q;
    widx_d  = widx_q;
    wlen_d  = wlen_q;
    wcnt_d  = wcnt_q;
    over_d  = over_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    if (aw_fire) begin
      wr_d   = W_DATA;
      widx_d = word_idx(s_axi.awaddr);
      wlen_d = s_axi.awlen;
      wcnt_d = '0;
      over_d = 1'b0;
      bid_d  = s_axi.awid;
    end
    // Beats past awlen are still committed; the sticky overrun flag turns the response into SLVERR.
    if (w_fire) begin
      widx_d = widx_q + idx_t'(1);
      wcnt_d = wcnt_q + 8'd1;
      over_d = over_q || (!s_axi.wlast && wcnt_q == wlen_q);
      wr_d   = s_axi.wlast ? W_RESP : W_DATA;
      bresp_d = !s_axi.wlast ? bresp_q : (!over_q && wcnt_q == wlen_q) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
    if (b_fire) wr_d = W_IDLE;
  end
  // The RAM read is issued one cycle ahead of the beat it feeds, so R_DATA sees data immediately.
  always_comb begin
    rd_d   = rd_q;
    ridx_d = ridx_q;
    rlen_d = rlen_q;
    rcnt_d = rcnt_q;
    lat_d  = lat_q;
    rid_d  = rid_q;
    re     = 1'b0;
    raddr  = ridx_q;
    if (ar_fire) begin
      rid_d  = s_axi.arid;
      ridx_d = word_idx(s_axi.araddr);
      rlen_d = s_axi.arlen;
      rcnt_d = '0;
      lat_d  = LW'(RD_LATENCY - 1);
      rd_d   = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
      re     = RD_LATENCY == 1;
      raddr  = word_idx(s_axi.araddr);
    end
    if (rd_q == R_WAIT) begin
      lat_d = lat_q - LW'(1);
      rd_d  = (lat_q == LW'(1)) ? R_DATA : R_WAIT;
      re    = lat_q == LW'(1);
    end
    if (r_fire) begin
      rd_d   = s_axi.rlast ? R_IDLE : R_DATA;
      rcnt_d = s_axi.rlast ? rcnt_q : rcnt_q + 8'd1;
      ridx_d = s_axi.rlast ? ridx_q : ridx_q + idx_t'(1);
      re     = !s_axi.rlast;
      raddr  = ridx_q + idx_t'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      wr_q       <= W_IDLE;
      widx_q     <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      over_q     <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      rd_q       <= R_IDLE;
      ridx_q     <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      lat_q      <= '0;
      rid_q      <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_q       <= wr_d;
      widx_q     <= widx_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      over_q     <= over_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rd_q       <= rd_d;
      ridx_q     <= ridx_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      lat_q      <= lat_d;
      rid_q      <= rid_d;
    end
  end
  vx_axi_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS_LOG2(MEM_WORDS_LOG2)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we_i   (w_fire),
    .waddr_i(widx_q),
    .wstrb_i(s_axi.wstrb),
    .wdata_i(s_axi.wdata),
    .re_i   (re),
    .raddr_i(raddr),
    .rdata_o(s_axi.rdata)
  );
endmodule

// File: tb/tb_vx_axi_mem_responder.sv
// tb_vx_axi_mem_responder: directed scenario bench for the AXI memory responder
module tb_vx_axi_mem_responder;
  localparam int DW = 64, AW = 25, IW = 32, ML = 6, LAT = 4, SW = DW/8;
  logic clk = 1'b0, reset = 1'b0;
  int total = 0, passed = 0;
  vx_axi_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_axi ();
  vx_axi_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS_LOG2(ML), .RD_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s_axi(s_axi)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic aw_send(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    int n = 0;
    s_axi.awvalid = 1'b1; s_axi.awaddr = a; s_axi.awid = id; s_axi.awlen = len;
    while (!s_axi.awready && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL aw_timeout: awready never 1"); end
    tick();
    s_axi.awvalid = 1'b0;
  endtask
  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
    int n = 0;
    s_axi.wvalid = 1'b1; s_axi.wdata = d; s_axi.wstrb = s; s_axi.wlast = last;
    while (!s_axi.wready && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL w_timeout: wready never 1"); end
    tick();
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
  endtask
  task automatic b_recv(output logic [IW-1:0] id, output logic [1:0] resp);
    int n = 0;
    s_axi.bready = 1'b1;
    while (!s_axi.bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL b_timeout: bvalid never 1"); end
    id = s_axi.bid; resp = s_axi.bresp;
    tick();
    s_axi.bready = 1'b0;
  endtask
  task automatic ar_send(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    int n = 0;
    s_axi.arvalid = 1'b1; s_axi.araddr = a; s_axi.arid = id; s_axi.arlen = len;
    while (!s_axi.arready && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL ar_timeout: arready never 1"); end
    tick();
    s_axi.arvalid = 1'b0;
  endtask
  task automatic r_wait(output int n);
    n = 0;
    while (!s_axi.rvalid && n < 50) begin tick(); n++; end
  endtask
  task automatic r_take(output logic [DW-1:0] d, output logic l, output logic [IW-1:0] id, output logic [1:0] resp);
    int n = 0;
    s_axi.rready = 1'b1;
    while (!s_axi.rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL r_timeout: rvalid never 1"); end
    d = s_axi.rdata; l = s_axi.rlast; id = s_axi.rid; resp = s_axi.rresp;
    tick();
    s_axi.rready = 1'b0;
  endtask
  task automatic test_reset();
    logic [5:0] flags;
    tick(); tick();
    flags = {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast};
    total++; if (flags !== 6'b0) $display("FAIL reset_flags: got %b want 000000", flags); else passed++;
    total++; if ({s_axi.bresp, s_axi.rresp} !== 4'b0) $display("FAIL reset_resp: got %b want 0000", {s_axi.bresp, s_axi.rresp}); else passed++;
    total++; if ({s_axi.bid, s_axi.rid} !== '0) $display("FAIL reset_ids: got %h want 0", {s_axi.bid, s_axi.rid}); else passed++;
    total++; if (s_axi.rdata !== '0) $display("FAIL reset_rdata: got %h want 0", s_axi.rdata); else passed++;
    reset = 1'b1;
    total++; if ({s_axi.awready, s_axi.arready} !== 2'b00) $display("FAIL ready_before_edge: got %b want 00", {s_axi.awready, s_axi.arready}); else passed++;
    tick();
    total++; if ({s_axi.awready, s_axi.arready, s_axi.wready} !== 3'b110) $display("FAIL ready_after_edge: got %b want 110", {s_axi.awready, s_axi.arready, s_axi.wready}); else passed++;
  endtask
  task automatic test_single();
    logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic l; int n;
    aw_send(25'h40, 32'h11, 8'd0);
    total++; if (s_axi.wready !== 1'b1) $display("FAIL single_wready: got %b want 1", s_axi.wready); else passed++;
    w_send({SW{8'hA5}}, '1, 1'b1);
    total++; if (s_axi.bvalid !== 1'b1) $display("FAIL single_bvalid_timing: got %b want 1", s_axi.bvalid); else passed++;
    b_recv(id, resp);
    total++; if (resp !== 2'b00) $display("FAIL single_bresp: got %b want 00", resp); else passed++;
    total++; if (id !== 32'h11) $display("FAIL single_bid: got %h want 11", id); else passed++;
    total++; if (s_axi.awready !== 1'b1) $display("FAIL single_awready_after_b: got %b want 1", s_axi.awready); else passed++;
    ar_send(25'h40, 32'h22, 8'd0);
    r_wait(n);
    total++; if (n !== LAT - 1) $display("FAIL single_rd_latency: got %0d want %0d", n, LAT - 1); else passed++;
    r_take(d, l, id, resp);
    total++; if (d !== {SW{8'hA5}}) $display("FAIL single_rdata: got %h want a5a5a5a5a5a5a5a5", d); else passed++;
    total++; if ({l, resp} !== 3'b100) $display("FAIL single_rlast_rresp: got %b want 100", {l, resp}); else passed++;
    total++; if (id !== 32'h22) $display("FAIL single_rid: got %h want 22", id); else passed++;
    total++; if (s_axi.arready !== 1'b1) $display("FAIL single_arready_after_r: got %b want 1", s_axi.arready); else passed++;
  endtask
  task automatic test_burst();
    logic [IW-1:0] id; logic [1:0] resp; int n;
    aw_send(25'h100, 32'h5, 8'd7);
    for (int k = 0; k < 8; k++) w_send(DW'(k), '1, k == 7);
    b_recv(id, resp);
    total++; if ({id, resp} !== {32'h5, 2'b00}) $display("FAIL burst_b: got id %h resp %b want 5/00", id, resp); else passed++;
    ar_send(25'h100, 32'h77, 8'd7);
    r_wait(n);
    for (int k = 0; k < 8; k++) begin
      total++; if (s_axi.rdata !== DW'(k)) $display("FAIL burst_data%0d: got %h want %h", k, s_axi.rdata, DW'(k)); else passed++;
      tick();
      total++; if ({s_axi.rvalid, s_axi.rdata} !== {1'b1, DW'(k)}) $display("FAIL burst_stall%0d: got %b/%h want 1/%h", k, s_axi.rvalid, s_axi.rdata, DW'(k)); else passed++;
      total++; if ({s_axi.rlast, s_axi.rid} !== {k == 7, 32'h77}) $display("FAIL burst_last_id%0d: got %b/%h want %b/77", k, s_axi.rlast, s_axi.rid, k == 7); else passed++;
      s_axi.rready = 1'b1;
      tick();
      s_axi.rready = 1'b0;
    end
    total++; if ({s_axi.rvalid, s_axi.arready} !== 2'b01) $display("FAIL burst_end: got %b want 01", {s_axi.rvalid, s_axi.arready}); else passed++;
  endtask
  task automatic test_back_to_back();
    int n;
    ar_send(25'h100, 32'h78, 8'd7);
    r_wait(n);
    s_axi.rready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if ({s_axi.rvalid, s_axi.rlast, s_axi.rdata} !== {1'b1, k == 7, DW'(k)}) $display("FAIL b2b_beat%0d: got %b/%b/%h want 1/%b/%h", k, s_axi.rvalid, s_axi.rlast, s_axi.rdata, k == 7, DW'(k)); else passed++;
      tick();
    end
    s_axi.rready = 1'b0;
    total++; if (s_axi.rvalid !== 1'b0) $display("FAIL b2b_end: got %b want 0", s_axi.rvalid); else passed++;
  endtask
  task automatic test_strobe();
    logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic l;
    aw_send(25'h80, 32'h1, 8'd0); w_send('1, '1, 1'b1); b_recv(id, resp);
    aw_send(25'h80, 32'h2, 8'd0); w_send('0, 8'h01, 1'b1); b_recv(id, resp);
    ar_send(25'h80, 32'h3, 8'd0);
    r_take(d, l, id, resp);
    total++; if (d !== 64'hFFFF_FFFF_FFFF_FF00) $display("FAIL strobe_rdata: got %h want ffffffffffffff00", d); else passed++;
  endtask
  task automatic test_slverr();
    logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic l;
    aw_send(25'h180, 32'hABCD, 8'd3);
    for (int k = 0; k < 3; k++) w_send(DW'(k), '1, k == 2);
    b_recv(id, resp);
    total++; if (resp !== 2'b10) $display("FAIL short_bresp: got %b want 10", resp); else passed++;
    total++; if (id !== 32'hABCD) $display("FAIL short_bid: got %h want abcd", id); else passed++;
    aw_send(25'h1C0, 32'h6, 8'd0);
    w_send(64'hAA, '1, 1'b0);
    w_send(64'hBB, '1, 1'b1);
    b_recv(id, resp);
    total++; if (resp !== 2'b10) $display("FAIL overrun_bresp: got %b want 10", resp); else passed++;
    ar_send(25'h1C8, 32'h7, 8'd0);
    r_take(d, l, id, resp);
    total++; if (d !== 64'hBB) $display("FAIL overrun_extra_beat: got %h want bb", d); else passed++;
  endtask
  task automatic test_wrap();
    logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic l;
    aw_send(25'h1FD, 32'h9, 8'd1);
    w_send(64'h1111, '1, 1'b0);
    w_send(64'h2222, '1, 1'b1);
    b_recv(id, resp);
    total++; if (resp !== 2'b00) $display("FAIL wrap_bresp: got %b want 00", resp); else passed++;
    ar_send(25'h0, 32'hA, 8'd0);
    r_take(d, l, id, resp);
    total++; if (d !== 64'h2222) $display("FAIL wrap_word0: got %h want 2222", d); else passed++;
    ar_send(25'h1F8, 32'hB, 8'd1);
    r_take(d, l, id, resp);
    total++; if ({l, d} !== {1'b0, 64'h1111}) $display("FAIL wrap_rd_beat0: got %b/%h want 0/1111", l, d); else passed++;
    r_take(d, l, id, resp);
    total++; if ({l, d} !== {1'b1, 64'h2222}) $display("FAIL wrap_rd_beat1: got %b/%h want 1/2222", l, d); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] d; logic l; int n;
    ar_send(25'h100, 32'h99, 8'd7);
    for (int k = 0; k < 3; k++) r_take(d, l, id, resp);
    total++; if ({s_axi.rvalid, s_axi.rdata} !== {1'b1, 64'd3}) $display("FAIL mid_beat3: got %b/%h want 1/3", s_axi.rvalid, s_axi.rdata); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({s_axi.rvalid, s_axi.rlast, s_axi.arready, s_axi.awready} !== 4'b0) $display("FAIL mid_reset_flags: got %b want 0000", {s_axi.rvalid, s_axi.rlast, s_axi.arready, s_axi.awready}); else passed++;
    total++; if ({s_axi.rdata, s_axi.rid} !== '0) $display("FAIL mid_reset_data: got %h want 0", {s_axi.rdata, s_axi.rid}); else passed++;
    tick();
    reset = 1'b1;
    total++; if (s_axi.arready !== 1'b0) $display("FAIL mid_arready_early: got %b want 0", s_axi.arready); else passed++;
    tick();
    total++; if (s_axi.arready !== 1'b1) $display("FAIL mid_arready_after: got %b want 1", s_axi.arready); else passed++;
    ar_send(25'h40, 32'h33, 8'd0);
    r_wait(n);
    total++; if (n !== LAT - 1) $display("FAIL mid_rd_latency: got %0d want %0d", n, LAT - 1); else passed++;
    r_take(d, l, id, resp);
    total++; if ({l, id, d} !== {1'b1, 32'h33, {SW{8'hA5}}}) $display("FAIL mid_fresh_read: got %b/%h/%h want 1/33/a5a5a5a5a5a5a5a5", l, id, d); else passed++;
  endtask
  initial begin
    s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awid = '0; s_axi.awlen = '0;
    s_axi.wvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arvalid = 1'b0; s_axi.araddr = '0; s_axi.arid = '0; s_axi.arlen = '0;
    s_axi.rready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_strobe();
    test_slverr();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
